// File: rtl/mult_pkg.sv
// Shared types and defaults for the round-robin shift-add multiplier scheduler.
package mult_pkg;

    localparam int WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/mult_dp.sv
// Shift-add datapath: multiplicand shifts left, multiplier shifts right, acc sums.
module mult_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               b0,
    output logic               b_zero,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (ld) begin
            acc_d = '0;
            a_d   = {{WIDTH{1'b0}}, a};
            b_d   = b;
        end else if (step) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign b0     = b_q[0];
    // True when the B value left after the current shift is zero.
    assign b_zero = ((b_q >> 1) == '0);
    assign acc    = acc_q;

endmodule

// File: rtl/seq_mult_sched.sv
// Round-robin scheduler/controller for two requesters sharing one shift-add multiplier.
// Optional early termination when B runs out of set bits: define SEQ_MULT_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | arbitrate, grant winner, load its operands
// RUN   | one add/shift iteration per cycle
// DONE  | product valid, done pulse, back to IDLE
module seq_mult_sched
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    req_id_t            prio_q, prio_d;
    req_id_t            done_id_q, done_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    req_id_t            winner;
    logic [1:0]         gnt_c;
    logic               ld, step;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               dp_b0, dp_b_zero;
    logic [2*WIDTH-1:0] dp_acc;
    logic               unused_dp_b0;

    assign winner = (req == 2'b11) ? prio_q : req[1];
    assign a_sel  = winner ? a1 : a0;
    assign b_sel  = winner ? b1 : b0;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        done_id_d = done_id_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        gnt_c     = 2'b00;
        ld        = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_c[winner] = 1'b1;
                    ld            = 1'b1;
                    cnt_d         = '0;
                    done_id_d     = winner;
                    prio_d        = ~winner;
                    state_d       = RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if (b_sel == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (dp_b_zero) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                product_d = dp_acc;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            done_id_q <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            done_id_q <= done_id_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .step   (step),
        .a      (a_sel),
        .b      (b_sel),
        .b0     (dp_b0),
        .b_zero (dp_b_zero),
        .acc    (dp_acc)
    );

    // The datapath handles B[0] internally; the controller never needs it.
    assign unused_dp_b0 = dp_b0;

    // Grant is combinational, so mask it while reset is held.
    assign gnt     = rst ? gnt_c : 2'b00;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    // Product shows the fresh result in the DONE cycle, then the held copy.
    assign product = done ? dp_acc : product_q;

endmodule

// File: tb/tb_seq_mult_sched.sv
// Table-driven bench for seq_mult_sched with a queue scoreboard of expected products.
module tb_seq_mult_sched;

    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [W-1:0]    a0, b0, a1, b1;
    logic [1:0]      gnt;
    logic            busy, done, done_id;
    logic [2*W-1:0]  product;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]     req;
        logic [W-1:0]   a0, b0, a1, b1;
        logic           hold;
        logic [1:0]     exp_gnt;
        logic [2*W-1:0] exp_prod;
    } vec_t;

    typedef struct {
        logic           id;
        logic [2*W-1:0] prod;
    } sb_t;

    sb_t            sb[$];
    logic [2*W-1:0] last_prod;
    vec_t           vecs[8];

    seq_mult_sched dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 2;
        end
        return 1;
`else
        return W + 1;
`endif
    endfunction

    // Called right after a falling edge with the DUT in IDLE; returns at the DONE cycle.
    task automatic apply(input vec_t v, input string name);
        int    n;
        int    lat;
        int    busy_n;
        bit    bad_gnt;
        sb_t   e;
        logic [W-1:0] wb;
        req = v.req; a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        #1;
        if (!done) chk({name, " held"}, product, last_prod);
        n = 0;
        while (gnt == 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({name, " gnt"}, gnt, v.exp_gnt);
        if (gnt == 2'b00) return;
        sb.push_back('{id: v.exp_gnt[1], prod: v.exp_prod});
        wb = v.exp_gnt[1] ? v.b1 : v.b0;
        lat = 0; busy_n = 0; bad_gnt = 0;
        do begin
            @(negedge clk);
            if (lat == 0 && !v.hold) begin
                req = 2'b00;
                a0 = W'($urandom); b0 = W'($urandom);
                a1 = W'($urandom); b1 = W'($urandom);
            end
            #1; lat++;
            if (busy) busy_n++;
            if (gnt != 2'b00) bad_gnt = 1;
        end while (!done && lat < 20);
        chk({name, " done seen"}, done, 1);
        chk({name, " latency"}, lat, exp_lat(wb));
        chk({name, " busy cycles"}, busy_n, lat);
        chk({name, " no gnt busy"}, bad_gnt, 0);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, " product"}, product, e.prod);
            chk({name, " done_id"}, done_id, e.id);
            last_prod = e.prod;
        end
    endtask

    initial begin
        vecs[0] = '{2'b01, 6'd13, 6'd11, 6'd0,  6'd0,  1'b0, 2'b01, 12'd143};
        vecs[1] = '{2'b10, 6'd0,  6'd0,  6'd0,  6'd37, 1'b0, 2'b10, 12'd0};
        vecs[2] = '{2'b11, 6'd63, 6'd63, 6'd5,  6'd9,  1'b1, 2'b01, 12'd3969};
        vecs[3] = '{2'b11, 6'd63, 6'd63, 6'd5,  6'd9,  1'b1, 2'b10, 12'd45};
        vecs[4] = '{2'b11, 6'd63, 6'd63, 6'd5,  6'd9,  1'b0, 2'b01, 12'd3969};
        vecs[5] = '{2'b01, 6'd7,  6'd0,  6'd0,  6'd0,  1'b0, 2'b01, 12'd0};
        vecs[6] = '{2'b10, 6'd0,  6'd0,  6'd63, 6'd1,  1'b0, 2'b10, 12'd63};
        vecs[7] = '{2'b01, 6'd1,  6'd32, 6'd0,  6'd0,  1'b0, 2'b01, 12'd32};

        // Reset with both requesting: everything quiet, then requester 0 first.
        rst = 1'b0; req = 2'b11;
        a0 = 6'd2; b0 = 6'd3; a1 = 6'd4; b1 = 6'd5;
        last_prod = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst gnt", gnt, 2'b00);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst product", product, 0);
        chk("rst done_id", done_id, 0);
        @(negedge clk);
        rst = 1'b1;
        apply('{2'b11, 6'd2, 6'd3, 6'd4, 6'd5, 1'b0, 2'b01, 12'd6}, "post-rst");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the third RUN cycle, requester 0 keeps asking throughout.
        @(negedge clk);
        req = 2'b01; a0 = 6'd21; b0 = 6'd3;
        #1;
        chk("midrst gnt", gnt, 2'b01);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst product", product, 0);
        chk("midrst gnt off", gnt, 2'b00);
        sb.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b1;
        apply('{2'b01, 6'd21, 6'd3, 6'd0, 6'd0, 1'b0, 2'b01, 12'd63}, "regrant");

        @(negedge clk);
        #1;
        chk("final held", product, last_prod);
        chk("final idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
